// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch initiator for the 5-stage RISC-V pipeline.
// Owns the PC, presents it to a combinational instruction memory, and captures
// the returned word into the IF/ID pipeline register. The per-edge update
// priority is reset > redirect > stall > advance.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch and bubble counters.
// When that macro is undefined, both counter outputs are tied to zero.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_inst,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  logic [31:0] r_pc;
  logic        r_if_id_valid;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_pc4;
  logic [31:0] r_if_id_inst;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_nxt;
  logic        w_capture;
  logic        w_bubble;
  logic        w_unused_lsbs;

  // The redirect target is always word aligned, so its two low bits are dropped.
  assign w_unused_lsbs = ^redirect_pc[1:0];
  assign w_pc_plus4    = r_pc + 32'd4;

  // Priority mux selecting the next PC and the kind of IF/ID update.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_capture = 1'b0;
    w_bubble  = 1'b0;
    if (redirect_valid) begin
      w_pc_nxt = {redirect_pc[31:2], 2'b00};
      w_bubble = 1'b1;
    end else if (flush && !stall) begin
      w_pc_nxt = w_pc_plus4;
      w_bubble = 1'b1;
    end else if (stall) begin
      w_pc_nxt = r_pc;
    end else begin
      w_pc_nxt  = w_pc_plus4;
      w_capture = 1'b1;
    end
  end

  // PC register and IF/ID register. A bubble keeps pc/pc4 and replaces the instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= 32'h0000_0000;
      r_if_id_pc4   <= 32'h0000_0004;
      r_if_id_inst  <= NOP_INST;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_capture) begin
        r_if_id_valid <= 1'b1;
        r_if_id_pc    <= r_pc;
        r_if_id_pc4   <= w_pc_plus4;
        r_if_id_inst  <= imem_inst;
      end else if (w_bubble) begin
        r_if_id_valid <= 1'b0;
        r_if_id_inst  <= NOP_INST;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_valid = r_if_id_valid;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_inst  = r_if_id_inst;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  // Performance counters: count captured instructions and inserted bubbles; wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt  <= 32'h0;
      r_bubble_cnt <= 32'h0;
    end else begin
      if (w_capture) r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (w_bubble)  r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign fetch_cnt  = 32'h0;
  assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: vector table with scoreboard queue, plus a
// hand-written counter sequence.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_inst;
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_inst(if_id_inst), .fetch_cnt(fetch_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Combinational memory: a distinct word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction
  assign imem_inst = mem_word(imem_addr);

  typedef struct {
    logic        rst, stl, fls, rv;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc, pc4, inst, fcnt, bcnt;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_f = 0;
  logic [31:0] m_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic stl, input logic fls, input logic rv,
                     input logic [31:0] rpc, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ep);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fls = fls; v.rv = rv; v.rpc = rpc;
    v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic rst, input logic stl, input logic fls, input logic rv,
                       input logic [31:0] rpc);
    reset = rst; stall = stl; flush = fls; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    exp_t g;
    if (v.rst) begin
      m_f = 0; m_b = 0;
    end else if (v.rv || (v.fls && !v.stl)) begin
      m_b = m_b + 1;
    end else if (!v.stl) begin
      m_f = m_f + 1;
    end
    e.addr  = v.e_addr;
    e.valid = v.e_valid;
    e.pc    = v.e_pc;
    e.pc4   = v.e_pc + 32'd4;
    e.inst  = v.e_valid ? mem_word(v.e_pc) : NOP;
`ifdef FETCH_PERF_CNT_EN
    e.fcnt = m_f;
    e.bcnt = m_b;
`else
    e.fcnt = 32'h0;
    e.bcnt = 32'h0;
`endif
    sb.push_back(e);
    apply(v.rst, v.stl, v.fls, v.rv, v.rpc);
    g = sb.pop_front();
    check("imem_addr",   imem_addr,   g.addr);
    check("if_id_valid", {31'h0, if_id_valid}, {31'h0, g.valid});
    check("if_id_pc",    if_id_pc,    g.pc);
    check("if_id_pc4",   if_id_pc4,   g.pc4);
    check("if_id_inst",  if_id_inst,  g.inst);
    check("fetch_cnt",   fetch_cnt,   g.fcnt);
    check("bubble_cnt",  bubble_cnt,  g.bcnt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    //   rst stl fls rv  rpc            addr           v  pc
    add(1, 0, 0, 0, 32'h0,          32'h0,          0, 32'h0);          // reset
    add(1, 0, 0, 0, 32'h0,          32'h0,          0, 32'h0);
    add(0, 0, 0, 0, 32'h0,          32'h4,          1, 32'h0);          // sequential fetch
    add(0, 0, 0, 0, 32'h0,          32'h8,          1, 32'h4);
    add(0, 0, 0, 0, 32'h0,          32'hC,          1, 32'h8);
    add(0, 0, 0, 0, 32'h0,          32'h10,         1, 32'hC);
    add(0, 1, 0, 0, 32'h0,          32'h10,         1, 32'hC);          // stall x3 at 0x10
    add(0, 1, 0, 0, 32'h0,          32'h10,         1, 32'hC);
    add(0, 1, 0, 0, 32'h0,          32'h10,         1, 32'hC);
    add(0, 0, 0, 0, 32'h0,          32'h14,         1, 32'h10);
    add(1, 0, 0, 0, 32'h0,          32'h0,          0, 32'h0);          // reset, run to 0xC
    add(0, 0, 0, 0, 32'h0,          32'h4,          1, 32'h0);
    add(0, 0, 0, 0, 32'h0,          32'h8,          1, 32'h4);
    add(0, 0, 0, 0, 32'h0,          32'hC,          1, 32'h8);
    add(0, 0, 0, 1, 32'hF0,         32'hF0,         0, 32'h8);          // redirect at 0xC
    add(0, 0, 0, 0, 32'h0,          32'hF4,         1, 32'hF0);
    add(0, 1, 0, 1, 32'h142,        32'h140,        0, 32'hF0);         // redirect beats stall
    add(0, 0, 0, 0, 32'h0,          32'h144,        1, 32'h140);
    add(0, 0, 1, 0, 32'h0,          32'h148,        0, 32'h140);        // flush
    add(0, 0, 0, 0, 32'h0,          32'h14C,        1, 32'h148);
    add(0, 1, 1, 0, 32'h0,          32'h14C,        1, 32'h148);        // flush+stall holds
    add(0, 0, 0, 0, 32'h0,          32'h150,        1, 32'h14C);
    add(0, 0, 0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC,  0, 32'h14C);        // wrap
    add(0, 0, 0, 0, 32'h0,          32'h0,          1, 32'hFFFF_FFFC);
    add(1, 1, 0, 0, 32'h0,          32'h0,          0, 32'h0);          // reset beats stall
    add(1, 0, 0, 1, 32'h80,         32'h0,          0, 32'h0);          // reset beats redirect
    add(0, 0, 0, 0, 32'h0,          32'h4,          1, 32'h0);

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

    // Counter sequence: 10 advances, 2 redirects, 3 stalls.
    apply(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 32'h0);
    apply(0, 0, 0, 1, 32'h100);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 32'h0);
    apply(0, 0, 0, 1, 32'h200);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 32'h0);
    check("seq_addr", imem_addr, 32'h20C);
    check("seq_pc",   if_id_pc,  32'h208);
`ifdef FETCH_PERF_CNT_EN
    check("seq_fetch_cnt",  fetch_cnt,  32'd10);
    check("seq_bubble_cnt", bubble_cnt, 32'd2);
`else
    check("seq_fetch_cnt",  fetch_cnt,  32'd0);
    check("seq_bubble_cnt", bubble_cnt, 32'd0);
`endif
    apply(1, 1, 0, 0, 32'h0);
    check("rst_fetch_cnt",  fetch_cnt,  32'd0);
    check("rst_bubble_cnt", bubble_cnt, 32'd0);
    check("rst_addr",       imem_addr,  32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
